// File: rtl/exe_wb_skid_stage_pkg.sv
// rtl/exe_wb_skid_stage_pkg.sv - shared widths, entry size and state encoding for the EXE->WB skid stage
package exe_wb_skid_stage_pkg;

  localparam int DSIZE_DEF = 32;
  localparam int ASIZE_DEF = 5;

  localparam int ENTRY_W = DSIZE_DEF + ASIZE_DEF + 1;

  // Encoding is {out_valid, skid_valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b10,
    ST_FULL  = 2'b11
  } stage_state_e;

  function automatic logic [1:0] stage_state(input logic out_valid, input logic skid_valid);
    return {out_valid, skid_valid};
  endfunction

endpackage

// File: rtl/exe_wb_entry_reg.sv
// rtl/exe_wb_entry_reg.sv - loadable {valid,data,waddr,wen} register with synchronous clear
module exe_wb_entry_reg
  import exe_wb_skid_stage_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int ASIZE = ASIZE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [DSIZE-1:0] load_data,
  input  logic [ASIZE-1:0] load_waddr,
  input  logic             load_wen,
  output logic             valid,
  output logic [DSIZE-1:0] data,
  output logic [ASIZE-1:0] waddr,
  output logic             wen
);

  // Clear drops the entry but leaves data/address in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      waddr <= '0;
      wen   <= 1'b0;
    end else if (clr) begin
      valid <= 1'b0;
      wen   <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      waddr <= load_waddr;
      wen   <= load_wen;
    end
  end

endmodule

// File: rtl/exe_wb_skid_stage.sv
// rtl/exe_wb_skid_stage.sv - EXE->WB two-entry skid stage; optional forwarding under EXE_WB_FWD_EN
module exe_wb_skid_stage
  import exe_wb_skid_stage_pkg::*;
#(
  parameter int DSIZE        = DSIZE_DEF,
  parameter int ASIZE        = ASIZE_DEF,
  parameter bit R0_HARDWIRED = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DSIZE-1:0] alu_in,
  input  logic [ASIZE-1:0] waddr_in,
  input  logic             wen_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] alu_out,
  output logic [ASIZE-1:0] waddr_out,
  output logic             wen_out
`ifdef EXE_WB_FWD_EN
  ,
  input  logic [ASIZE-1:0] fwd_raddr,
  output logic             fwd_hit,
  output logic [DSIZE-1:0] fwd_data
`endif
);

  logic             skid_valid;
  logic [DSIZE-1:0] skid_data;
  logic [ASIZE-1:0] skid_waddr;
  logic             skid_wen;

  logic accept, drain, wen_masked;
  logic out_load, out_clr, skid_load, skid_clr;
  logic [DSIZE-1:0] out_src_data;
  logic [ASIZE-1:0] out_src_waddr;
  logic             out_src_wen;

  assign in_ready   = ~skid_valid;
  assign accept     = in_valid & in_ready & ~flush;
  assign drain      = out_valid & out_ready;
  assign wen_masked = wen_in & ~(R0_HARDWIRED && (waddr_in == '0));

  // Output slot refills from skid when one is parked, otherwise straight from EXE.
  assign out_load  = skid_valid ? drain : (accept & (~out_valid | drain));
  assign out_clr   = flush | (drain & ~out_load);
  assign skid_load = accept & out_valid & ~drain;
  assign skid_clr  = flush | (skid_valid & drain);

  assign out_src_data  = skid_valid ? skid_data  : alu_in;
  assign out_src_waddr = skid_valid ? skid_waddr : waddr_in;
  assign out_src_wen   = skid_valid ? skid_wen   : wen_masked;

  exe_wb_entry_reg #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .clr        (out_clr),
    .load       (out_load),
    .load_data  (out_src_data),
    .load_waddr (out_src_waddr),
    .load_wen   (out_src_wen),
    .valid      (out_valid),
    .data       (alu_out),
    .waddr      (waddr_out),
    .wen        (wen_out)
  );

  exe_wb_entry_reg #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_skid_reg (
    .clk        (clk),
    .rst        (rst),
    .clr        (skid_clr),
    .load       (skid_load),
    .load_data  (alu_in),
    .load_waddr (waddr_in),
    .load_wen   (wen_masked),
    .valid      (skid_valid),
    .data       (skid_data),
    .waddr      (skid_waddr),
    .wen        (skid_wen)
  );

`ifdef EXE_WB_FWD_EN
  // Skid holds the younger entry so it wins; R0 never hits since its stored wen is 0.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (skid_valid && skid_wen && (skid_waddr == fwd_raddr)) begin
      fwd_hit  = 1'b1;
      fwd_data = skid_data;
    end else if (out_valid && wen_out && (waddr_out == fwd_raddr)) begin
      fwd_hit  = 1'b1;
      fwd_data = alu_out;
    end
  end
`endif

endmodule

// File: tb/tb_exe_wb_skid_stage.sv
// tb/tb_exe_wb_skid_stage.sv - self-checking bench for exe_wb_skid_stage against a queue model
module tb_exe_wb_skid_stage;
  import exe_wb_skid_stage_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst, flush, in_valid, wen_in, out_ready;
  logic [DW-1:0] alu_in;
  logic [AW-1:0] waddr_in;
  logic          in_ready, out_valid, wen_out;
  logic [DW-1:0] alu_out;
  logic [AW-1:0] waddr_out;
`ifdef EXE_WB_FWD_EN
  logic [AW-1:0] fwd_raddr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    logic          w;
  } ent_t;
  ent_t q[$];

  exe_wb_skid_stage #(.DSIZE(DW), .ASIZE(AW), .R0_HARDWIRED(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_in    (alu_in),
    .waddr_in  (waddr_in),
    .wen_in    (wen_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out   (alu_out),
    .waddr_out (waddr_out),
    .wen_out   (wen_out)
`ifdef EXE_WB_FWD_EN
    ,
    .fwd_raddr (fwd_raddr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the stage is a FIFO of depth two; reset/flush empty it.
  task automatic tick();
    bit   acc, drn;
    ent_t e;
    acc = in_valid && (q.size() < 2) && !flush;
    drn = (q.size() > 0) && out_ready;
    e.d = alu_in;
    e.a = waddr_in;
    e.w = wen_in && (waddr_in != '0);
    @(posedge clk);
    if (rst || flush) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [AW-1:0] a, input logic w);
    in_valid = v;
    alu_in   = d;
    waddr_in = a;
    wen_in   = w;
  endtask

  task automatic clear_stage();
    drive(1'b0, '0, '0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      tests++;
      if (stage_state(out_valid, !in_ready) == 2'b01) begin
        fails++;
        $display("FAIL illegal_state: out_valid=%0b skid_valid=%0b, required not (0,1)", out_valid, !in_ready);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    tests += 5;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    if (alu_out !== '0) begin fails++; $display("FAIL reset_alu_out: got %h want 0", alu_out); end
    if (waddr_out !== '0) begin fails++; $display("FAIL reset_waddr_out: got %0d want 0", waddr_out); end
    if (wen_out !== 1'b0) begin fails++; $display("FAIL reset_wen_out: got %0b want 0", wen_out); end
  endtask

  task automatic test_streaming();
    logic [DW-1:0] exp_d;
    clear_stage();
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      exp_d = 32'h11 * i;
      drive(1'b1, exp_d, AW'(i), 1'b1);
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL stream_in_ready[%0d]: got %0b want 1", i, in_ready); end
      tick();
      tests += 4;
      if (out_valid !== 1'b1) begin fails++; $display("FAIL stream_valid[%0d]: got %0b want 1", i, out_valid); end
      if (alu_out !== exp_d) begin fails++; $display("FAIL stream_data[%0d]: got %h want %h", i, alu_out, exp_d); end
      if (waddr_out !== AW'(i)) begin fails++; $display("FAIL stream_waddr[%0d]: got %0d want %0d", i, waddr_out, i); end
      if (wen_out !== 1'b1) begin fails++; $display("FAIL stream_wen[%0d]: got %0b want 1", i, wen_out); end
    end
    drive(1'b0, '0, '0, 1'b0);
    tick();
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL stream_drained: got %0b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    clear_stage();
    out_ready = 1'b0;
    drive(1'b1, 32'hA, 5'd6, 1'b1); tick();
    drive(1'b1, 32'hB, 5'd7, 1'b1); tick();
    drive(1'b0, '0, '0, 1'b0);
    tests += 3;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_full_ready: got %0b want 0", in_ready); end
    if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_full_valid: got %0b want 1", out_valid); end
    if (alu_out !== 32'hA) begin fails++; $display("FAIL bp_held: got %h want a", alu_out); end
    tick();
    tests++;
    if (alu_out !== 32'hA) begin fails++; $display("FAIL bp_still_held: got %h want a", alu_out); end
    out_ready = 1'b1;
    tick();
    tests += 3;
    if (alu_out !== 32'hB) begin fails++; $display("FAIL bp_second: got %h want b", alu_out); end
    if (waddr_out !== 5'd7) begin fails++; $display("FAIL bp_second_waddr: got %0d want 7", waddr_out); end
    if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_back: got %0b want 1", in_ready); end
    tick();
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_empty: got %0b want 0", out_valid); end
  endtask

  task automatic test_r0_mask();
    clear_stage();
    out_ready = 1'b1;
    drive(1'b1, 32'hDEAD, 5'd0, 1'b1); tick();
    drive(1'b0, '0, '0, 1'b0);
    tests += 4;
    if (out_valid !== 1'b1) begin fails++; $display("FAIL r0_valid: got %0b want 1", out_valid); end
    if (alu_out !== 32'hDEAD) begin fails++; $display("FAIL r0_data: got %h want dead", alu_out); end
    if (waddr_out !== 5'd0) begin fails++; $display("FAIL r0_waddr: got %0d want 0", waddr_out); end
    if (wen_out !== 1'b0) begin fails++; $display("FAIL r0_wen: got %0b want 0", wen_out); end
    drive(1'b1, 32'hBEEF, 5'd9, 1'b1); tick();
    drive(1'b0, '0, '0, 1'b0);
    tests++;
    if (wen_out !== 1'b1) begin fails++; $display("FAIL r9_wen: got %0b want 1", wen_out); end
  endtask

  task automatic test_flush_full();
    clear_stage();
    out_ready = 1'b0;
    drive(1'b1, 32'h1, 5'd1, 1'b1); tick();
    drive(1'b1, 32'h2, 5'd2, 1'b1); tick();
    drive(1'b1, 32'hC, 5'd3, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    tests += 3;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_valid: got %0b want 0", out_valid); end
    if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_ready: got %0b want 1", in_ready); end
    if (wen_out !== 1'b0) begin fails++; $display("FAIL flush_wen: got %0b want 0", wen_out); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_leak[%0d]: got valid=%0b data=%h want no entry", i, out_valid, alu_out); end
    end
  endtask

  task automatic test_reset_midstream();
    clear_stage();
    out_ready = 1'b0;
    drive(1'b1, 32'h9, 5'd4, 1'b1); tick();
    drive(1'b0, '0, '0, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    tests += 4;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid: got %0b want 0", out_valid); end
    if (alu_out !== '0) begin fails++; $display("FAIL rstmid_data: got %h want 0", alu_out); end
    if (waddr_out !== '0) begin fails++; $display("FAIL rstmid_waddr: got %0d want 0", waddr_out); end
    if (in_ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready: got %0b want 1", in_ready); end
    drive(1'b1, 32'h5, 5'd3, 1'b1); tick();
    drive(1'b0, '0, '0, 1'b0);
    tests += 2;
    if (out_valid !== 1'b1) begin fails++; $display("FAIL rstmid_accept_valid: got %0b want 1", out_valid); end
    if (alu_out !== 32'h5) begin fails++; $display("FAIL rstmid_accept_data: got %h want 5", alu_out); end
  endtask

  task automatic test_random();
    bit hold = 0;
    clear_stage();
    for (int i = 0; i < 400; i++) begin
      if (!hold)
        drive(1'($urandom_range(0, 1)), $urandom, AW'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      hold      = in_valid && !flush && (q.size() >= 2);
      tick();
      flush = 1'b0;
      tests += 2;
      if (in_ready !== (q.size() < 2)) begin fails++; $display("FAIL rand_in_ready[%0d]: got %0b want %0b", i, in_ready, q.size() < 2); end
      if (out_valid !== (q.size() > 0)) begin fails++; $display("FAIL rand_out_valid[%0d]: got %0b want %0b", i, out_valid, q.size() > 0); end
      if (q.size() > 0) begin
        tests++;
        if ({alu_out, waddr_out, wen_out} !== {q[0].d, q[0].a, q[0].w}) begin
          fails++;
          $display("FAIL rand_entry[%0d]: got %h/%0d/%0b want %h/%0d/%0b", i, alu_out, waddr_out, wen_out, q[0].d, q[0].a, q[0].w);
        end
      end
    end
    drive(1'b0, '0, '0, 1'b0);
  endtask

`ifdef EXE_WB_FWD_EN
  task automatic test_fwd();
    clear_stage();
    out_ready = 1'b0;
    drive(1'b1, 32'h40, 5'd4, 1'b1); tick();
    drive(1'b1, 32'h44, 5'd4, 1'b1); tick();
    drive(1'b0, '0, '0, 1'b0);
    fwd_raddr = 5'd4; #1;
    tests += 2;
    if (fwd_hit !== 1'b1) begin fails++; $display("FAIL fwd_hit4: got %0b want 1", fwd_hit); end
    if (fwd_data !== 32'h44) begin fails++; $display("FAIL fwd_data4: got %h want 44", fwd_data); end
    fwd_raddr = 5'd0; #1;
    tests++;
    if (fwd_hit !== 1'b0) begin fails++; $display("FAIL fwd_hit0: got %0b want 0", fwd_hit); end
  endtask
`endif

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
`ifdef EXE_WB_FWD_EN
    fwd_raddr = '0;
`endif
    test_reset();
    test_streaming();
    test_backpressure();
    test_r0_mask();
    test_flush_full();
    test_reset_midstream();
    test_random();
`ifdef EXE_WB_FWD_EN
    test_fwd();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule

// File: doc/exe_wb_skid_stage.md
Name: exe_wb_skid_stage

Overview:
- Parametrised successor to the plain EXE→WB pipeline register.
- Carries ALU result, destination register address and write-enable from EXE to WB through a two-entry skid buffer with valid/ready handshake, synchronous flush and R0 write masking.
- WB back-pressure (`out_ready` low) no longer drops results.
- Combinational `in_ready` depends only on registered state, which breaks the ready path.

Parameters:
- DSIZE, `DSIZE (from define.v), datapath width.
- ASIZE, `ASIZE (from define.v), register-address width.
- R0_HARDWIRED, 1, when 1 a write to address 0 leaves with `out_wen` forced to 0.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous: discard all held entries this edge.
- in_valid  input  1  EXE presents a result.
- in_ready  output  1  stage can accept; equals NOT skid_valid.
- alu_in  input  DSIZE  ALU result.
- waddr_in  input  ASIZE  destination register.
- wen_in  input  1  register-file write enable.
- out_valid  output  1  WB entry valid.
- out_ready  input  1  WB consumes entry.
- alu_out  output  DSIZE  registered result.
- waddr_out  output  ASIZE  registered destination.
- wen_out  output  1  registered write enable, masked per R0_HARDWIRED.

Behaviour:
- Handshake definitions:
  - accept = in_valid & in_ready.
  - drain = out_valid & out_ready.
  - Valid may not depend on ready. A producer holding in_valid with in_ready low keeps its data stable.
- Storage:
  - Output register {out_valid, alu_out, waddr_out, wen_out}.
  - Skid register {skid_valid, skid_data, skid_waddr, skid_wen}.
- States are encoded by the valid bits:
  - EMPTY (0,0), BUSY (out_valid=1, skid_valid=0), FULL (1,1).
  - (0,1) is illegal. Assertion in the bench.
- Transitions, when rst=0 and flush=0:
  - EMPTY: accept → BUSY, output register ← input. No accept → stay.
  - BUSY, accept & drain → BUSY, output register ← input.
  - BUSY, accept & !drain → FULL, skid ← input, output register held.
  - BUSY, !accept & drain → EMPTY.
  - BUSY, neither → hold.
  - FULL: in_ready=0. drain → BUSY, output register ← skid. Else hold.
- Latency: accept at edge N gives out_valid at N+1 (1 cycle) when not back-pressured. Throughput is 1/cycle with out_ready held high.
- Ordering: strict FIFO, the skid entry is always younger than the output entry.
- Masking: when R0_HARDWIRED=1 and waddr_in==0, the stored wen is 0. Data and address still propagate.
- Entries with wen_in=0 travel normally (valid bubble, no write).
- Reset (highest priority):
  - out_valid=0, skid_valid=0, alu_out=0, waddr_out=0, wen_out=0, skid registers=0.
  - Result: in_ready=1 the cycle after reset.
- flush (second priority):
  - Clears out_valid and skid_valid. Data registers keep their values; wen_out is cleared.
  - An input presented in a flush cycle is discarded, not accepted.
  - in_ready reads 1 the next cycle.
- Reset or flush mid-FULL drops both entries. No partial state remains.
- wen_out is only meaningful when out_valid=1. WB must qualify with out_valid.

Optional Feature:
- Macro: EXE_WB_FWD_EN.
- Defined: adds input fwd_raddr [ASIZE] and outputs fwd_hit [1] and fwd_data [DSIZE]. All forwarding logic is combinational from registered state.
  - If skid_valid & skid_wen & skid_waddr==fwd_raddr: hit=1, data=skid_data (youngest wins).
  - Else if out_valid & wen_out & waddr_out==fwd_raddr: hit=1, data=alu_out.
  - Else: hit=0, data=0.
  - fwd_raddr==0 never hits when R0_HARDWIRED=1.
- Undefined: ports absent, no forwarding logic.

Decomposition:
- define.v already holds DSIZE/ASIZE.
- Add to the shared package:
  - A state-encoding constant set (ST_EMPTY, ST_BUSY, ST_FULL) for the bench and debug.
  - An entry-width constant DSIZE+ASIZE+1.
- One natural sub-module: exe_wb_entry_reg, a loadable {valid,data,waddr,wen} register with synchronous clear. It is instanced twice, for output and skid.

Test Plan:
- Streaming: out_ready=1, accept alu_in 0x11,0x22,0x33 to waddr 1,2,3 on consecutive edges → each appears on alu_out one cycle later; in_ready stays 1.
- Back-pressure: out_ready=0, accept 0xA then 0xB → FULL, in_ready=0, alu_out=0xA held. Raise out_ready → 0xA drains, then 0xB. No loss, no reorder.
- R0 mask: wen_in=1, waddr_in=0, alu_in=0xDEAD → out_valid=1, alu_out=0xDEAD, wen_out=0.
- Flush in FULL with in_valid=1 and data 0xC → next cycle out_valid=0, in_ready=1; 0xC never appears.
- Reset mid-stream (rst=1 one cycle while BUSY) → all outputs 0, in_ready=1; a following accept of 0x5 appears after 1 cycle.
- EXE_WB_FWD_EN, FULL state, out entry waddr=4/0x40 and skid entry waddr=4/0x44, fwd_raddr=4 → fwd_hit=1, fwd_data=0x44; fwd_raddr=0 → fwd_hit=0.
